// File: rtl/fx_switch_ctrl.sv
`default_nettype none
// =============================================================================
// fx_switch_ctrl : click-free effect reconfiguration (fade-out, settle, fade-in)
// Rev 1.0
// =============================================================================
module fx_switch_ctrl #(
  parameter int RAMP_STEP      = 8,
  parameter int SETTLE_SAMPLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sample_valid,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic        req_enable_bitcrush,
  input  logic        req_enable_delay,
  input  logic [4:0]  req_bit_depth,
  input  logic [15:0] req_delay_num_samples,
  input  logic [7:0]  req_feedback_amount,
  input  logic [7:0]  req_delay_effect_amount,
  output logic        enable_bitcrush,
  output logic        enable_delay,
  output logic [4:0]  bit_depth,
  output logic [15:0] delay_num_samples,
  output logic [7:0]  feedback_amount,
  output logic [7:0]  delay_effect_amount,
  output logic [7:0]  fade_gain,
  output logic        busy
);

  localparam logic [8:0]  C_STEP   = 9'(RAMP_STEP);
  localparam logic [15:0] C_SETTLE = 16'(SETTLE_SAMPLES);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FADE_OUT = 2'd1,
    SETTLE   = 2'd2,
    FADE_IN  = 2'd3
  } state_t;

  typedef struct packed {
    logic        en_bc;
    logic        en_dl;
    logic [4:0]  depth;
    logic [15:0] dly;
    logic [7:0]  fb;
    logic [7:0]  mix;
  } cfg_t;

  localparam cfg_t C_CFG_RST = {1'b0, 1'b0, 5'd24, 16'd0, 8'd0, 8'd0};

  state_t      state, state_nx;
  cfg_t        applied, applied_nx;
  cfg_t        pend, pend_nx;
  logic [7:0]  gain, gain_nx;
  logic [15:0] cnt, cnt_nx;

  cfg_t        req;
  logic        structural;
  logic [7:0]  gain_dn;
  logic [8:0]  gain_sum;
  logic [7:0]  gain_up;

  assign req = {req_enable_bitcrush, req_enable_delay, req_bit_depth,
                req_delay_num_samples, req_feedback_amount, req_delay_effect_amount};

  // Only fields that alter the signal path topology force a fade.
  assign structural = (req.en_bc != applied.en_bc) || (req.en_dl != applied.en_dl) ||
                      (req.depth != applied.depth) || (req.dly != applied.dly);

  assign gain_dn  = (C_STEP >= {1'b0, gain}) ? 8'd0 : (gain - C_STEP[7:0]);
  assign gain_sum = {1'b0, gain} + C_STEP;
  assign gain_up  = gain_sum[8] ? 8'hFF : gain_sum[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      applied <= C_CFG_RST;
      pend    <= '0;
      gain    <= 8'hFF;
      cnt     <= 16'd0;
    end else begin
      state   <= state_nx;
      applied <= applied_nx;
      pend    <= pend_nx;
      gain    <= gain_nx;
      cnt     <= cnt_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    applied_nx = applied;
    pend_nx    = pend;
    gain_nx    = gain;
    cnt_nx     = cnt;
    case (state)
      IDLE: begin
        // A tick arriving with the transfer is ignored; the ramp starts on the next one.
        if (cfg_valid) begin
          if (structural) begin
            pend_nx  = req;
            state_nx = FADE_OUT;
          end else begin
            applied_nx.fb  = req.fb;
            applied_nx.mix = req.mix;
          end
        end
      end
      FADE_OUT: begin
        if (sample_valid) begin
          gain_nx = gain_dn;
          if (gain_dn == 8'd0) begin
            state_nx   = SETTLE;
            applied_nx = pend;
            cnt_nx     = C_SETTLE;
          end
        end
      end
      SETTLE: begin
        if (sample_valid) begin
          cnt_nx = cnt - 16'd1;
          if (cnt == 16'd1) state_nx = FADE_IN;
        end
      end
      FADE_IN: begin
        if (sample_valid) begin
          gain_nx = gain_up;
          if (gain_up == 8'hFF) state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign cfg_ready           = (state == IDLE);
  assign busy                = (state != IDLE);
  assign fade_gain           = gain;
  assign enable_bitcrush     = applied.en_bc;
  assign enable_delay        = applied.en_dl;
  assign bit_depth           = applied.depth;
  assign delay_num_samples   = applied.dly;
  assign feedback_amount     = applied.fb;
  assign delay_effect_amount = applied.mix;

endmodule
`default_nettype wire

// File: tb/tb_fx_switch_ctrl.sv
`default_nettype none
// =============================================================================
// tb_fx_switch_ctrl : scoreboard bench, instance A (step 64, settle 2), B (step 255, settle 3)
// Rev 1.0
// =============================================================================
module tb_fx_switch_ctrl;

  localparam int STEP_A = 64;
  localparam int SET_A  = 2;
  localparam int STEP_B = 255;
  localparam int SET_B  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, sample_valid, cfg_valid;
  logic        req_en_bc, req_en_dl;
  logic [4:0]  req_bd;
  logic [15:0] req_dly;
  logic [7:0]  req_fb, req_mix;

  logic        d_rdy   [2];
  logic        d_bsy   [2];
  logic [7:0]  d_gain  [2];
  logic        d_en_bc [2];
  logic        d_en_dl [2];
  logic [4:0]  d_bd    [2];
  logic [15:0] d_dly   [2];
  logic [7:0]  d_fb    [2];
  logic [7:0]  d_mix   [2];

  fx_switch_ctrl #(.RAMP_STEP(STEP_A), .SETTLE_SAMPLES(SET_A)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid),
    .cfg_valid(cfg_valid), .cfg_ready(d_rdy[0]),
    .req_enable_bitcrush(req_en_bc), .req_enable_delay(req_en_dl),
    .req_bit_depth(req_bd), .req_delay_num_samples(req_dly),
    .req_feedback_amount(req_fb), .req_delay_effect_amount(req_mix),
    .enable_bitcrush(d_en_bc[0]), .enable_delay(d_en_dl[0]), .bit_depth(d_bd[0]),
    .delay_num_samples(d_dly[0]), .feedback_amount(d_fb[0]),
    .delay_effect_amount(d_mix[0]), .fade_gain(d_gain[0]), .busy(d_bsy[0])
  );

  fx_switch_ctrl #(.RAMP_STEP(STEP_B), .SETTLE_SAMPLES(SET_B)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid),
    .cfg_valid(cfg_valid), .cfg_ready(d_rdy[1]),
    .req_enable_bitcrush(req_en_bc), .req_enable_delay(req_en_dl),
    .req_bit_depth(req_bd), .req_delay_num_samples(req_dly),
    .req_feedback_amount(req_fb), .req_delay_effect_amount(req_mix),
    .enable_bitcrush(d_en_bc[1]), .enable_delay(d_en_dl[1]), .bit_depth(d_bd[1]),
    .delay_num_samples(d_dly[1]), .feedback_amount(d_fb[1]),
    .delay_effect_amount(d_mix[1]), .fade_gain(d_gain[1]), .busy(d_bsy[1])
  );

  typedef struct packed {
    logic        en_bc;
    logic        en_dl;
    logic [4:0]  bd;
    logic [15:0] dly;
    logic [7:0]  fb;
    logic [7:0]  mix;
  } cfg_t;

  typedef struct packed {
    logic       rdy;
    logic       bsy;
    logic [7:0] gain;
    cfg_t       cfg;
  } snap_t;

  // Reference model: phase 0 idle, 1 fading out, 2 settling, 3 fading in.
  int   m_phase [2];
  int   m_gain  [2];
  int   m_left  [2];
  cfg_t m_app   [2];
  cfg_t m_pend  [2];

  snap_t q0[$];
  snap_t q1[$];
  int    total = 0;
  int    bad   = 0;

  function automatic int step_of(int k);
    return (k == 0) ? STEP_A : STEP_B;
  endfunction

  function automatic int settle_of(int k);
    return (k == 0) ? SET_A : SET_B;
  endfunction

  function automatic void model_reset(int k);
    m_phase[k] = 0;
    m_gain[k]  = 255;
    m_left[k]  = 0;
    m_app[k]   = {1'b0, 1'b0, 5'd24, 16'd0, 8'd0, 8'd0};
    m_pend[k]  = '0;
  endfunction

  function automatic void model_step(int k);
    cfg_t rq;
    int   s;
    rq = {req_en_bc, req_en_dl, req_bd, req_dly, req_fb, req_mix};
    s  = step_of(k);
    if (!rst_n) begin
      model_reset(k);
      return;
    end
    case (m_phase[k])
      0: if (cfg_valid) begin
           if (rq.en_bc != m_app[k].en_bc || rq.en_dl != m_app[k].en_dl ||
               rq.bd != m_app[k].bd || rq.dly != m_app[k].dly) begin
             m_pend[k]  = rq;
             m_phase[k] = 1;
           end else begin
             m_app[k].fb  = rq.fb;
             m_app[k].mix = rq.mix;
           end
         end
      1: if (sample_valid) begin
           m_gain[k] = (m_gain[k] - s > 0) ? m_gain[k] - s : 0;
           if (m_gain[k] == 0) begin
             m_phase[k] = 2;
             m_app[k]   = m_pend[k];
             m_left[k]  = settle_of(k);
           end
         end
      2: if (sample_valid) begin
           m_left[k] = m_left[k] - 1;
           if (m_left[k] == 0) m_phase[k] = 3;
         end
      3: if (sample_valid) begin
           m_gain[k] = (m_gain[k] + s < 255) ? m_gain[k] + s : 255;
           if (m_gain[k] == 255) m_phase[k] = 0;
         end
      default: m_phase[k] = 0;
    endcase
  endfunction

  function automatic snap_t exp_snap(int k);
    return {(m_phase[k] == 0), (m_phase[k] != 0), 8'(m_gain[k]), m_app[k]};
  endfunction

  function automatic snap_t act_snap(int k);
    return {d_rdy[k], d_bsy[k], d_gain[k], d_en_bc[k], d_en_dl[k], d_bd[k],
            d_dly[k], d_fb[k], d_mix[k]};
  endfunction

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", nm, got, exp, $time);
    end
  endtask

  // Inputs change one unit after the falling edge; expectations become due at the next rising edge.
  task automatic tick(input logic sv, input logic cv);
    snap_t e0, e1;
    sample_valid = sv;
    cfg_valid    = cv;
    model_step(0);
    model_step(1);
    e0 = exp_snap(0);
    e1 = exp_snap(1);
    @(posedge clk);
    q0.push_back(e0);
    q1.push_back(e1);
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    snap_t e, a;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      a = act_snap(0);
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL snapA t=%0t got=%h exp=%h", $time, a, e);
      end
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      a = act_snap(1);
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL snapB t=%0t got=%h exp=%h", $time, a, e);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_a [10];
    int n;
    exp_a = '{191, 127, 63, 0, 0, 0, 64, 128, 192, 255};

    rst_n = 1'b0; sample_valid = 1'b0; cfg_valid = 1'b0;
    req_en_bc = 1'b0; req_en_dl = 1'b0; req_bd = 5'd24;
    req_dly = 16'd0; req_fb = 8'd0; req_mix = 8'd0;
    model_reset(0);
    model_reset(1);
    repeat (3) tick(1'b0, 1'b0);
    chk("rst_gain", int'(d_gain[0]), 255);
    chk("rst_depth", int'(d_bd[0]), 24);
    chk("rst_busy", int'(d_bsy[0]), 0);
    chk("rst_ready", int'(d_rdy[0]), 1);
    rst_n = 1'b1;
    tick(1'b0, 1'b0);

    // Non-structural update applies directly without a fade.
    req_fb = 8'd100;
    tick(1'b0, 1'b1);
    chk("ns_fb", int'(d_fb[0]), 100);
    chk("ns_busy", int'(d_bsy[0]), 0);
    chk("ns_gain", int'(d_gain[0]), 255);

    // Structural transfer coinciding with a tick: the tick must not ramp.
    req_en_dl = 1'b1;
    tick(1'b1, 1'b1);
    chk("xfer_gain", int'(d_gain[0]), 255);
    chk("xfer_busy", int'(d_bsy[0]), 1);
    chk("xfer_en_dl", int'(d_en_dl[0]), 0);
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b0);
      chk($sformatf("seq_gain%0d", i), int'(d_gain[0]), exp_a[i]);
      chk($sformatf("seq_busy%0d", i), int'(d_bsy[0]), (i < 9) ? 1 : 0);
      chk($sformatf("seq_en_dl%0d", i), int'(d_en_dl[0]), (i >= 3) ? 1 : 0);
      if (i == 0) chk("b_out_one_tick", int'(d_gain[1]), 0);
      if (i == 4) begin
        chk("b_in_one_tick", int'(d_gain[1]), 255);
        chk("b_idle", int'(d_bsy[1]), 0);
      end
    end

    // Freeze in FADE_OUT without ticks.
    req_en_bc = 1'b1;
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b0);
    chk("frz_gain0", int'(d_gain[0]), 191);
    repeat (50) tick(1'b0, 1'b0);
    chk("frz_gain", int'(d_gain[0]), 191);
    chk("frz_busy", int'(d_bsy[0]), 1);
    chk("frz_en_bc", int'(d_en_bc[0]), 0);

    // Held-off configuration during FADE_IN.
    n = 0;
    while (m_phase[0] != 3 && n < 20) begin
      tick(1'b1, 1'b0);
      n++;
    end
    req_fb  = 8'd7;
    req_dly = 16'd5;
    n = 0;
    while (m_phase[0] != 0 && n < 20) begin
      chk("holdoff_ready", int'(d_rdy[0]), 0);
      tick(1'b1, 1'b1);
      n++;
    end
    chk("idle_ready", int'(d_rdy[0]), 1);
    tick(1'b0, 1'b1);
    chk("held_xfer_busy", int'(d_bsy[0]), 1);
    chk("held_xfer_gain", int'(d_gain[0]), 255);

    // Asynchronous reset in SETTLE.
    n = 0;
    while (m_phase[0] != 2 && n < 20) begin
      tick(1'b1, 1'b0);
      n++;
    end
    chk("in_settle_gain", int'(d_gain[0]), 0);
    rst_n = 1'b0;
    #1;
    chk("arst_gain", int'(d_gain[0]), 255);
    chk("arst_busy", int'(d_bsy[0]), 0);
    chk("arst_dly", int'(d_dly[0]), 0);
    chk("arst_fb", int'(d_fb[0]), 0);
    chk("arst_depth", int'(d_bd[0]), 24);
    model_reset(0);
    model_reset(1);
    tick(1'b1, 1'b0);
    rst_n = 1'b1;
    repeat (10) tick(1'b1, 1'b0);
    chk("post_rst_dly", int'(d_dly[0]), 0);
    chk("post_rst_busy", int'(d_bsy[0]), 0);

    // Randomised traffic, with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 1) begin
          req_en_bc = 1'($urandom_range(0, 1));
          req_en_dl = 1'($urandom_range(0, 1));
          req_bd    = ($urandom_range(0, 1) == 1) ? 5'd24 : 5'($urandom_range(0, 31));
          req_dly   = 16'($urandom_range(0, 3));
        end
        req_fb  = 8'($urandom_range(0, 255));
        req_mix = 8'($urandom_range(0, 255));
      end
      tick(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end
    rst_n = 1'b1;
    repeat (2) tick(1'b0, 1'b0);
    chk("queue_drain", q0.size() + q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
